vme_regbank_xbar: RTL

//  Parametrised cern-be-vme slave decoder: NREG writable 32-bit registers plus NSUB cern-be-vme submap ports.

---
 rtl/vme_regbank_xbar_pkg.sv | 9 +
 rtl/vme_sub_txn.sv | 45 ++++
 rtl/vme_regbank_xbar.sv | 112 +++++++++++
 3 files changed

// File: rtl/vme_regbank_xbar_pkg.sv
// vme_xbar_pkg: shared types, constants and address helpers for the VME register bank crossbar
package vme_xbar_pkg;
  typedef enum logic {ST_IDLE, ST_WAIT} sub_st_t;
  localparam logic [31:0] C_TMO_DATA = 32'hDEAD_BEEF;
  // Window index of word address w; negative or >= NSUB means "not a submap"
  function automatic int win_idx(input int w, input int aw);
    return (w >> aw) - 1;
  endfunction
endpackage

// File: rtl/vme_sub_txn.sv
// vme_sub_txn: one-direction submap transaction tracker with Done mux and ack timeout
module vme_sub_txn
  import vme_xbar_pkg::*;
#(
  parameter int NSUB    = 2,
  parameter int IW      = 1,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IW-1:0]   idx,
  input  logic [NSUB-1:0] done_i,
  output logic            busy,
  output logic            ack,
  output logic            tmo,
  output logic [IW-1:0]   sel
);
  sub_st_t    st, st_nx;
  logic [7:0] cnt;
  logic       hit, expire;
  assign hit    = done_i[sel];
  assign expire = cnt == 8'(TIMEOUT);
  // State, latched target submap and wait counter (counts 1..TIMEOUT while waiting)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= ST_IDLE;
      cnt <= '0;
      sel <= '0;
    end else begin
      st  <= st_nx;
      cnt <= st == ST_IDLE ? 8'd1 : cnt + 8'd1;
      sel <= st == ST_IDLE && start ? idx : sel;
    end
  end
  // Leave WAIT on the selected submap's Done or on expiry
  always_comb
    st_nx = st == ST_IDLE ? (start ? ST_WAIT : ST_IDLE) : (hit || expire ? ST_IDLE : ST_WAIT);
  // Ack on termination; a real Done in the expiry cycle wins over the timeout
  always_comb begin
    busy = st == ST_WAIT;
    ack  = busy && (hit || expire);
    tmo  = busy && expire && !hit;
  end
endmodule

// File: rtl/vme_regbank_xbar.sv
// vme_regbank_xbar: VME slave decoder with a register bank and submap ports
module vme_regbank_xbar
  import vme_xbar_pkg::*;
#(
  parameter int          ADDR_W  = 8,
  parameter int          NREG    = 4,
  parameter int          NSUB    = 2,
  parameter int          SUB_AW  = 2,
  parameter int          TIMEOUT = 15,
  parameter logic [31:0] RST_VAL = 32'h0
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [ADDR_W-1:2]   VMEAddr,
  output logic [31:0]         VMERdData,
  input  logic [31:0]         VMEWrData,
  input  logic                VMERdMem,
  input  logic                VMEWrMem,
  output logic                VMERdDone,
  output logic                VMEWrDone,
  output logic [NREG*32-1:0]  regs_o,
  output logic [SUB_AW-1:0]   sub_VMEAddr_o,
  output logic [31:0]         sub_VMEWrData_o,
  input  logic [NSUB*32-1:0]  sub_VMERdData_i,
  output logic [NSUB-1:0]     sub_VMERdMem_o,
  output logic [NSUB-1:0]     sub_VMEWrMem_o,
  input  logic [NSUB-1:0]     sub_VMERdDone_i,
  input  logic [NSUB-1:0]     sub_VMEWrDone_i,
  output logic                err_o,
  output logic [7:0]          tmo_cnt_o
);
  localparam int IW = NSUB > 1 ? $clog2(NSUB) : 1;
  localparam int RW = NREG > 1 ? $clog2(NREG) : 1;
  logic [ADDR_W-1:2] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_v;
  logic [31:0]       regs_q [NREG];
  logic [31:0]       sub_rd [NSUB];
  int                rd_win, wr_win;
  logic              rd_reg, rd_sub, rd_bad, wr_reg, wr_sub, wr_bad;
  logic              rd_busy, rd_ack, rd_tmo, wr_busy, wr_ack, wr_tmo;
  logic [IW-1:0]     rd_idx, wr_idx, rd_sel, wr_sel;
  logic [8:0]        tmo_sum;
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    assign regs_o[32*i +: 32] = regs_q[i];
  end
  for (genvar i = 0; i < NSUB; i++) begin : g_sub
    assign sub_rd[i] = sub_VMERdData_i[32*i +: 32];
  end
  assign sub_VMEWrData_o = wr_data;
  // Decode both paths; any request while its direction is waiting is dropped
  always_comb begin
    rd_win         = win_idx(int'(VMEAddr), SUB_AW);
    wr_win         = win_idx(int'(wr_addr), SUB_AW);
    rd_idx         = IW'(rd_win);
    wr_idx         = IW'(wr_win);
    rd_reg         = VMERdMem && !rd_busy && int'(VMEAddr) < NREG;
    rd_sub         = VMERdMem && !rd_busy && rd_win >= 0 && rd_win < NSUB;
    rd_bad         = VMERdMem && !rd_busy && !rd_reg && !rd_sub;
    wr_reg         = wr_v && !wr_busy && int'(wr_addr) < NREG;
    wr_sub         = wr_v && !wr_busy && wr_win >= 0 && wr_win < NSUB;
    wr_bad         = wr_v && !wr_busy && !wr_reg && !wr_sub;
    sub_VMERdMem_o = rd_sub ? NSUB'(1) << rd_idx : '0;
    sub_VMEWrMem_o = wr_sub ? NSUB'(1) << wr_idx : '0;
    sub_VMEAddr_o  = wr_sub ? wr_addr[SUB_AW+1:2] : VMEAddr[SUB_AW+1:2];
    tmo_sum        = {1'b0, tmo_cnt_o} + 9'(rd_tmo) + 9'(wr_tmo);
  end
  // Write input stage
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_v    <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_v    <= VMEWrMem;
      wr_addr <= VMEAddr;
      wr_data <= VMEWrData;
    end
  end
  // Register bank, written from the write stage
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= RST_VAL;
    end else if (wr_reg) begin
      regs_q[wr_addr[RW+1:2]] <= wr_data;
    end
  end
  // Read-out stage, acks, error pulse and saturating timeout count
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      VMERdDone <= 1'b0;
      VMERdData <= '0;
      VMEWrDone <= 1'b0;
      err_o     <= 1'b0;
      tmo_cnt_o <= '0;
    end else begin
      VMERdDone <= rd_reg || rd_bad || rd_ack;
      VMERdData <= rd_reg ? regs_q[VMEAddr[RW+1:2]] : rd_tmo ? C_TMO_DATA : rd_ack ? sub_rd[rd_sel] : '0;
      VMEWrDone <= wr_reg || wr_bad || wr_ack;
      err_o     <= rd_bad || rd_tmo || wr_bad || wr_tmo;
      tmo_cnt_o <= tmo_sum[8] ? 8'hFF : tmo_sum[7:0];
    end
  end
  vme_sub_txn #(.NSUB(NSUB), .IW(IW), .TIMEOUT(TIMEOUT)) u_rd (
    .clk(Clk), .rst(Rst), .start(rd_sub), .idx(rd_idx), .done_i(sub_VMERdDone_i),
    .busy(rd_busy), .ack(rd_ack), .tmo(rd_tmo), .sel(rd_sel)
  );
  vme_sub_txn #(.NSUB(NSUB), .IW(IW), .TIMEOUT(TIMEOUT)) u_wr (
    .clk(Clk), .rst(Rst), .start(wr_sub), .idx(wr_idx), .done_i(sub_VMEWrDone_i),
    .busy(wr_busy), .ack(wr_ack), .tmo(wr_tmo), .sel(wr_sel)
  );
endmodule
